// File: rtl/ifu_fetch_if.sv
// rtl/ifu_fetch_if.sv - fetch unit bus bundle: redirect, AXI4-Lite AR/R, IDU handoff, trace
interface ifu_fetch_if #(
  parameter int XLEN = 32
);
  logic            pc_redirect_valid;
  logic [XLEN-1:0] pc_redirect;
  logic            arvalid;
  logic [XLEN-1:0] araddr;
  logic            arready;
  logic            rvalid;
  logic [XLEN-1:0] rdata;
  logic [1:0]      rresp;
  logic            rready;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_inst;
  logic            out_fault;
  logic            trace_valid;
  logic [XLEN-1:0] trace_addr;
  logic [XLEN-1:0] trace_data;
  logic [31:0]     inst_count;

  modport master (
    input  pc_redirect_valid, pc_redirect, arready, rvalid, rdata, rresp, out_ready,
    output arvalid, araddr, rready, out_valid, out_pc, out_inst, out_fault,
           trace_valid, trace_addr, trace_data, inst_count
  );

  modport slave (
    output pc_redirect_valid, pc_redirect, arready, rvalid, rdata, rresp, out_ready,
    input  arvalid, araddr, rready, out_valid, out_pc, out_inst, out_fault,
           trace_valid, trace_addr, trace_data, inst_count
  );
endinterface

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - multi-cycle instruction fetch: one AXI4-Lite read per PC, handoff to IDU
module ifu_fetch #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clock,
  input  logic        reset,
  ifu_fetch_if.master bus
);
  typedef enum logic [2:0] {IDLE, AR, R, OUT, WAIT_PC} state_t;

  state_t          state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic [XLEN-1:0] inst, inst_n;
  logic            arvalid, arvalid_n;
  logic            rready, rready_n;
  logic            out_valid, out_valid_n;
  logic            fault, fault_n;
  logic            trace_valid, trace_valid_n;
  logic [31:0]     inst_count, inst_count_n;
  logic            launch;
  logic [XLEN-1:0] launch_pc;

  always_comb begin
    state_n       = state;
    pc_n          = pc;
    inst_n        = inst;
    arvalid_n     = arvalid;
    rready_n      = rready;
    out_valid_n   = out_valid;
    fault_n       = fault;
    trace_valid_n = 1'b0;
    inst_count_n  = inst_count;
    launch        = 1'b0;
    launch_pc     = pc;

    case (state)
      IDLE: launch = 1'b1;
      AR: begin
        if (bus.arready) begin
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
          state_n   = R;
        end
      end
      R: begin
        if (bus.rvalid) begin
          inst_n        = bus.rdata;
          fault_n       = (bus.rresp != 2'b00);
          trace_valid_n = (bus.rresp == 2'b00);
          rready_n      = 1'b0;
          out_valid_n   = 1'b1;
          state_n       = OUT;
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          out_valid_n  = 1'b0;
          inst_count_n = inst_count + 32'd1;
          if (bus.pc_redirect_valid) begin
            launch    = 1'b1;
            launch_pc = bus.pc_redirect;
          end else begin
            state_n = WAIT_PC;
          end
        end
      end
      WAIT_PC: begin
        if (bus.pc_redirect_valid) begin
          launch    = 1'b1;
          launch_pc = bus.pc_redirect;
        end
      end
      default: state_n = IDLE;
    endcase

    // A misaligned PC never reaches the bus; it is reported as a faulted fetch.
    if (launch) begin
      pc_n = launch_pc;
      if (launch_pc[1:0] != 2'b00) begin
        state_n     = OUT;
        out_valid_n = 1'b1;
        fault_n     = 1'b1;
        inst_n      = '0;
      end else begin
        state_n   = AR;
        arvalid_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      inst        <= '0;
      arvalid     <= 1'b0;
      rready      <= 1'b0;
      out_valid   <= 1'b0;
      fault       <= 1'b0;
      trace_valid <= 1'b0;
      inst_count  <= 32'd0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      inst        <= inst_n;
      arvalid     <= arvalid_n;
      rready      <= rready_n;
      out_valid   <= out_valid_n;
      fault       <= fault_n;
      trace_valid <= trace_valid_n;
      inst_count  <= inst_count_n;
    end
  end

  assign bus.arvalid     = arvalid;
  assign bus.araddr      = pc;
  assign bus.rready      = rready;
  assign bus.out_valid   = out_valid;
  assign bus.out_pc      = pc;
  assign bus.out_inst    = inst;
  assign bus.out_fault   = fault;
  assign bus.trace_valid = trace_valid;
  assign bus.trace_addr  = pc;
  assign bus.trace_data  = inst;
  assign bus.inst_count  = inst_count;
endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - scoreboard bench for ifu_fetch
module tb_ifu_fetch;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } exp_t;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_pass;
  int   exp_count;
  exp_t sb[$];

  ifu_fetch_if #(.XLEN(32)) bus ();

  ifu_fetch #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h, expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic sb_compare();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check("out_pc", bus.out_pc, e.pc);
    check("out_inst", bus.out_inst, e.inst);
    check("out_fault", 32'(bus.out_fault), 32'(e.fault));
  endtask

  task automatic run_fetch(input logic [31:0] addr, input int ar_wait, input int r_wait,
                           input logic [31:0] data, input logic [1:0] resp, input int stall,
                           input bit redir_out, input logic [31:0] next_pc);
    int   cyc;
    int   n;
    int   traces;
    exp_t e;
    n = 0;
    while (!bus.arvalid && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!bus.arvalid) begin
      check("ar_timeout", 32'd0, 32'd1);
      return;
    end
    check("araddr", bus.araddr, addr);
    cyc = 0;
    for (int i = 0; i < ar_wait; i++) begin
      bus.arready = 1'b0;
      @(negedge clock);
      cyc++;
      check("ar_hold_valid", 32'(bus.arvalid), 32'd1);
      check("ar_hold_addr", bus.araddr, addr);
    end
    bus.arready = 1'b1;
    @(negedge clock);
    cyc++;
    bus.arready = 1'b0;
    check("ar_drop", 32'(bus.arvalid), 32'd0);
    check("rready_up", 32'(bus.rready), 32'd1);
    e.pc = addr;
    e.inst = data;
    e.fault = (resp != 2'b00);
    sb.push_back(e);
    for (int i = 0; i < r_wait; i++) begin
      bus.rvalid = 1'b0;
      bus.pc_redirect_valid = 1'b1;
      bus.pc_redirect = 32'h0bad_0000;
      @(negedge clock);
      cyc++;
      check("r_hold", 32'(bus.rready), 32'd1);
    end
    bus.pc_redirect_valid = 1'b0;
    bus.rvalid = 1'b1;
    bus.rdata = data;
    bus.rresp = resp;
    @(negedge clock);
    cyc++;
    bus.rvalid = 1'b0;
    bus.rdata = $urandom;
    bus.rresp = 2'b00;
    check("out_valid", 32'(bus.out_valid), 32'd1);
    check("rready_drop", 32'(bus.rready), 32'd0);
    check("latency", 32'(cyc), 32'(2 + ar_wait + r_wait));
    check("trace_valid", 32'(bus.trace_valid), 32'(resp == 2'b00));
    if (resp == 2'b00) begin
      check("trace_addr", bus.trace_addr, addr);
      check("trace_data", bus.trace_data, data);
    end
    traces = 0;
    for (int i = 0; i < stall; i++) begin
      bus.out_ready = 1'b0;
      @(negedge clock);
      check("stall_valid", 32'(bus.out_valid), 32'd1);
      check("stall_pc", bus.out_pc, addr);
      check("stall_inst", bus.out_inst, data);
      check("stall_count", bus.inst_count, 32'(exp_count));
      traces += int'(bus.trace_valid);
    end
    if (stall > 0) check("trace_once", 32'(traces), 32'd0);
    bus.out_ready = 1'b1;
    if (redir_out) begin
      bus.pc_redirect_valid = 1'b1;
      bus.pc_redirect = next_pc;
    end
    sb_compare();
    @(negedge clock);
    bus.out_ready = 1'b0;
    bus.pc_redirect_valid = 1'b0;
    exp_count++;
    check("count", bus.inst_count, 32'(exp_count));
    check("out_drop", 32'(bus.out_valid), 32'd0);
    check("skip_wait", 32'(bus.arvalid), 32'(redir_out));
  endtask

  task automatic redirect_wait(input logic [31:0] pc);
    bus.pc_redirect_valid = 1'b1;
    bus.pc_redirect = pc;
    @(negedge clock);
    bus.pc_redirect_valid = 1'b0;
  endtask

  task automatic fault_fetch(input logic [31:0] addr);
    exp_t e;
    e.pc = addr;
    e.inst = 32'd0;
    e.fault = 1'b1;
    sb.push_back(e);
    check("mis_no_ar", 32'(bus.arvalid), 32'd0);
    check("mis_valid", 32'(bus.out_valid), 32'd1);
    check("mis_trace", 32'(bus.trace_valid), 32'd0);
    bus.out_ready = 1'b1;
    sb_compare();
    @(negedge clock);
    bus.out_ready = 1'b0;
    exp_count++;
    check("mis_count", bus.inst_count, 32'(exp_count));
    check("mis_no_ar2", 32'(bus.arvalid), 32'd0);
  endtask

  initial begin
    clock = 1'b0;
    reset = 1'b1;
    n_checks = 0;
    n_pass = 0;
    exp_count = 0;
    bus.pc_redirect_valid = 1'b0;
    bus.pc_redirect = '0;
    bus.arready = 1'b0;
    bus.rvalid = 1'b0;
    bus.rdata = '0;
    bus.rresp = 2'b00;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_arvalid", 32'(bus.arvalid), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_inst", bus.out_inst, 32'd0);
    check("rst_count", bus.inst_count, 32'd0);
    check("rst_pc", bus.out_pc, RESET_PC);
    reset = 1'b0;
    @(negedge clock);
    check("ar_first", 32'(bus.arvalid), 32'd1);

    run_fetch(RESET_PC, 0, 0, 32'h0000_0413, 2'b00, 0, 1'b0, 32'd0);
    redirect_wait(32'h8000_0010);
    run_fetch(32'h8000_0010, 4, 3, 32'h00a0_0093, 2'b00, 5, 1'b1, 32'h8000_0020);
    run_fetch(32'h8000_0020, 0, 1, 32'hdead_beef, 2'b10, 0, 1'b0, 32'd0);
    redirect_wait(32'h8000_0002);
    fault_fetch(32'h8000_0002);
    redirect_wait(32'h8000_0100);

    // abandon a read mid-flight with reset between clock edges
    check("pre_rst_ar", 32'(bus.arvalid), 32'd1);
    bus.arready = 1'b1;
    @(negedge clock);
    bus.arready = 1'b0;
    check("pre_rst_r", 32'(bus.rready), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("arst_arvalid", 32'(bus.arvalid), 32'd0);
    check("arst_rready", 32'(bus.rready), 32'd0);
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_fault", 32'(bus.out_fault), 32'd0);
    check("arst_trace", 32'(bus.trace_valid), 32'd0);
    check("arst_inst", bus.out_inst, 32'd0);
    check("arst_count", bus.inst_count, 32'd0);
    check("arst_pc", bus.araddr, RESET_PC);
    sb.delete();
    exp_count = 0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("ar_restart", 32'(bus.arvalid), 32'd1);
    run_fetch(RESET_PC, 1, 0, 32'h0010_0073, 2'b00, 2, 1'b0, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
